// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN        = 32'd32;
    localparam int unsigned INSTR_BYTES = 32'd4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HOLD   = 3'd4,
        ST_HALTED = 3'd5
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_INC   = 2'd1,
        PC_REDIR = 2'd2
    } pc_sel_e;

    // Sequential PC step; wraps naturally at the top of the address space.
    function automatic logic [XLEN-1:0] pc_plus_instr(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface fetch_stage_if;
    import fetch_pkg::*;

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register with its next-PC select (hold, +4, redirect, reset).
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  pc_sel_e         sel,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] pc_r;

    // PC update according to the select from the fetch FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else begin
            case (sel)
                PC_HOLD:  pc_r <= pc_r;
                PC_INC:   pc_r <= pc_plus_instr(pc_r);
                PC_REDIR: pc_r <= target;
                default:  pc_r <= pc_r;
            endcase
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, word held for decode.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    fetch_stage_if.master    imem,
    output logic [XLEN-1:0]  instruction,
    output logic [XLEN-1:0]  inst_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             halt,
    output logic             fetch_fault
);

    fetch_state_e    state_r;
    fetch_state_e    state_nxt_s;
    pc_sel_e         pc_sel_s;
    logic [XLEN-1:0] pc_s;
    logic [XLEN-1:0] target_s;
    logic            misalign_s;
    logic            capture_s;
    logic            fault_set_s;
    logic [XLEN-1:0] instruction_r;
    logic [XLEN-1:0] inst_pc_r;
    logic            fault_r;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign target_s   = redirect_pc;
    assign misalign_s = redirect && (redirect_pc[1:0] != 2'b00);
`else
    assign target_s   = {redirect_pc[XLEN-1:2], redirect_pc[1:0] & 2'b00};
    assign misalign_s = 1'b0;
`endif

    fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk    (clk),
        .reset  (reset),
        .sel    (pc_sel_s),
        .target (target_s),
        .pc     (pc_s)
    );

    // Next state and datapath controls; halt beats redirect beats normal flow
    always_comb begin
        state_nxt_s = state_r;
        pc_sel_s    = PC_HOLD;
        capture_s   = 1'b0;
        fault_set_s = 1'b0;
        if (state_r == ST_HALTED) begin
            state_nxt_s = ST_HALTED;
        end else if (halt) begin
            state_nxt_s = ST_HALTED;
        end else if (misalign_s) begin
            state_nxt_s = ST_HALTED;
            fault_set_s = 1'b1;
        end else if (redirect) begin
            pc_sel_s = PC_REDIR;
            case (state_r)
                ST_REQ:   state_nxt_s = imem.imem_req_ready ? ST_DRAIN : ST_REQ;
                ST_WAIT:  state_nxt_s = imem.imem_rsp_valid ? ST_REQ : ST_DRAIN;
                // A response arriving with the redirect still retires the old request
                ST_DRAIN: state_nxt_s = imem.imem_rsp_valid ? ST_REQ : ST_DRAIN;
                default:  state_nxt_s = ST_REQ;
            endcase
        end else begin
            case (state_r)
                ST_IDLE:  state_nxt_s = ST_REQ;
                ST_REQ:   state_nxt_s = imem.imem_req_ready ? ST_WAIT : ST_REQ;
                ST_WAIT: begin
                    if (imem.imem_rsp_valid) begin
                        capture_s   = 1'b1;
                        pc_sel_s    = PC_INC;
                        state_nxt_s = ST_HOLD;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                ST_DRAIN: state_nxt_s = imem.imem_rsp_valid ? ST_REQ : ST_DRAIN;
                ST_HOLD:  state_nxt_s = inst_ready ? ST_REQ : ST_HOLD;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State register, captured word for decode and sticky fault flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            instruction_r <= NOP_INSTR;
            inst_pc_r     <= {XLEN{1'b0}};
            fault_r       <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (capture_s) begin
                instruction_r <= imem.imem_rsp_data;
                inst_pc_r     <= pc_s;
            end
            if (fault_set_s) begin
                fault_r <= 1'b1;
            end
        end
    end

    assign imem.imem_req_valid = (state_r == ST_REQ);
    assign imem.imem_req_addr  = pc_s;
    assign inst_valid          = (state_r == ST_HOLD);
    assign instruction         = instruction_r;
    assign inst_pc             = inst_pc_r;
    assign fetch_fault         = fault_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: memory model, expected-word queue, directed scenarios.
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction, inst_pc, redirect_pc;
    logic        inst_valid, inst_ready, redirect, halt, fetch_fault;

    exp_t        exp_q[$];
    int          hs_cyc[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          acc_budget = 0;
    int          rsp_delay = 0;
    bit          acc_seen;
    logic [31:0] acc_addr;
    bit          rsp_pend = 1'b0;
    int          rsp_wait = 0;
    logic [31:0] rsp_addr;

    fetch_stage_if imem ();

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem),
        .instruction (instruction),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.word = mem_word(pc);
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1; redirect = 1'b0; halt = 1'b0; acc_budget = 0;
        tick(3);
        @(negedge clk);
        check_eq({tag, "_rst_req_valid"}, {31'd0, imem.imem_req_valid}, 32'd0);
        check_eq({tag, "_rst_req_addr"}, imem.imem_req_addr, RST_PC);
        check_eq({tag, "_rst_inst_valid"}, {31'd0, inst_valid}, 32'd0);
        check_eq({tag, "_rst_instruction"}, instruction, NOP_INSTR);
        check_eq({tag, "_rst_inst_pc"}, inst_pc, 32'd0);
        check_eq({tag, "_rst_fault"}, {31'd0, fetch_fault}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq({tag, "_idle_no_req"}, {31'd0, imem.imem_req_valid}, 32'd0);
        @(negedge clk);
        check_eq({tag, "_first_req"}, {31'd0, imem.imem_req_valid}, 32'd1);
        check_eq({tag, "_first_addr"}, imem.imem_req_addr, RST_PC);
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (inst_valid) break;
        end
        check_eq(tag, {31'd0, inst_valid}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_sb_empty(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        check_eq(tag, exp_q.size(), 32'd0);
    endtask

    // Cycle counter for handshake spacing
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: ready while budget remains, response rsp_delay cycles after acceptance
    initial begin
        imem.imem_req_ready = 1'b0;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = 32'd0;
        forever begin
            @(negedge clk);
            acc_seen = imem.imem_req_valid && imem.imem_req_ready;
            acc_addr = imem.imem_req_addr;
            @(posedge clk); #1;
            imem.imem_rsp_valid = 1'b0;
            if (acc_seen) begin
                rsp_pend = 1'b1;
                rsp_wait = rsp_delay;
                rsp_addr = acc_addr;
                if (acc_budget > 0) acc_budget--;
            end
            if (rsp_pend) begin
                if (rsp_wait == 0) begin
                    imem.imem_rsp_valid = 1'b1;
                    imem.imem_rsp_data  = mem_word(rsp_addr);
                    rsp_pend = 1'b0;
                end else begin
                    rsp_wait--;
                end
            end
            imem.imem_req_ready = (acc_budget > 0);
        end
    end

    // Scoreboard: every decode handshake must match the oldest expected word
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && inst_valid && inst_ready) begin
                check_eq("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("sb_inst_pc", inst_pc, e.pc);
                    check_eq("sb_instruction", instruction, e.word);
                    hs_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_cnt;
        inst_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; halt = 1'b0;
        do_reset("t0");

        // Zero-wait memory, decode always ready: 0x0, 0x4, 0x8 every 3 cycles
        hs_cyc.delete();
        for (int i = 0; i < 3; i++) push_exp(RST_PC + 32'(4 * i));
        acc_budget = 3;
        wait_sb_empty("t1_drain", 40);
        check_eq("t1_hs_count", hs_cyc.size(), 32'd3);
        if (hs_cyc.size() == 3) begin
            check_eq("t1_gap0", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
            check_eq("t1_gap1", 32'(hs_cyc[2] - hs_cyc[1]), 32'd3);
        end

        // Decode stalls 5 cycles in HOLD
        inst_ready = 1'b0;
        push_exp(32'h0000_000C);
        acc_budget = 1;
        wait_valid("t2_valid", 20);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("t2_instr_stable", instruction, mem_word(32'h0000_000C));
            check_eq("t2_pc_stable", inst_pc, 32'h0000_000C);
            check_eq("t2_no_req", {31'd0, imem.imem_req_valid}, 32'd0);
            check_eq("t2_pc_next", imem.imem_req_addr, 32'h0000_0010);
        end
        @(posedge clk); #1;
        inst_ready = 1'b1;
        wait_sb_empty("t2_drain", 10);

        // Redirect in WAIT before the response: late word must be dropped
        rsp_delay = 3;
        acc_budget = 2;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem.imem_req_valid && imem.imem_req_ready) break;
        end
        check_eq("t3_accept_addr", imem.imem_req_addr, 32'h0000_0010);
        @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        push_exp(32'h0000_0100);
        @(posedge clk); #1;
        redirect = 1'b0; rsp_delay = 0;
        @(negedge clk);
        check_eq("t3_drain_no_req", {31'd0, imem.imem_req_valid}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            if (imem.imem_req_valid) break;
            @(negedge clk);
        end
        check_eq("t3_req_addr", imem.imem_req_addr, 32'h0000_0100);
        @(posedge clk); #1;
        wait_sb_empty("t3_drain", 20);

        // Memory not ready for 4 cycles, redirect in cycle 2
        @(negedge clk);
        check_eq("t4_c1_addr", imem.imem_req_addr, 32'h0000_0104);
        check_eq("t4_c1_valid", {31'd0, imem.imem_req_valid}, 32'd1);
        @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        @(negedge clk);
        check_eq("t4_c2_addr", imem.imem_req_addr, 32'h0000_0104);
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        check_eq("t4_c3_addr", imem.imem_req_addr, 32'h0000_0200);
        check_eq("t4_c3_valid", {31'd0, imem.imem_req_valid}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("t4_c4_addr", imem.imem_req_addr, 32'h0000_0200);
        @(posedge clk); #1;
        push_exp(32'h0000_0200);
        acc_budget = 1;
        wait_sb_empty("t4_drain", 20);

        // Halt while holding a word: no more requests until reset
        inst_ready = 1'b0;
        acc_budget = 1;
        wait_valid("t5_valid", 20);
        halt = 1'b1;
        @(posedge clk); #1;
        halt = 1'b0;
        @(negedge clk);
        check_eq("t5_inst_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("t5_no_req", {31'd0, imem.imem_req_valid}, 32'd0);
        inst_ready = 1'b1;
        acc_budget = 4;
        req_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (imem.imem_req_valid || inst_valid) req_cnt++;
        end
        check_eq("t5_halted_quiet", req_cnt, 32'd0);
        @(posedge clk); #1;
        do_reset("t5");

        // PC wraps from the last word to zero
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(posedge clk); #1;
        redirect = 1'b0;
        push_exp(32'hFFFF_FFFC);
        push_exp(32'h0000_0000);
        acc_budget = 2;
        wait_sb_empty("t7_wrap", 30);

        // Misaligned redirect target
        redirect = 1'b1; redirect_pc = 32'h0000_0102;
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
`ifdef FETCH_MISALIGN_CHECK_EN
        check_eq("t6_fault", {31'd0, fetch_fault}, 32'd1);
        check_eq("t6_halted_no_req", {31'd0, imem.imem_req_valid}, 32'd0);
        tick(3);
        check_eq("t6_fault_sticky", {31'd0, fetch_fault}, 32'd1);
        check_eq("t6_halted_inst_valid", {31'd0, inst_valid}, 32'd0);
`else
        check_eq("t6_no_fault", {31'd0, fetch_fault}, 32'd0);
        check_eq("t6_aligned_addr", imem.imem_req_addr, 32'h0000_0100);
        check_eq("t6_req_valid", {31'd0, imem.imem_req_valid}, 32'd1);
        @(posedge clk); #1;
        push_exp(32'h0000_0100);
        acc_budget = 1;
        wait_sb_empty("t6_drain", 20);
        check_eq("t6_no_fault_after", {31'd0, fetch_fault}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
